// File: rtl/bdd_node_loader.sv
// Streams a byte-serial BDD node table into two SRAM write ports.
// A header byte gives the node count; each node is an 8-byte record.
module bdd_node_loader #(
    parameter int RAM1_DATA_WIDTH = 34,
    parameter int RAM2_DATA_WIDTH = 18,
    parameter int ADDR_WIDTH      = 8,
    parameter int DEPTH           = 32
) (
    input  logic                       clk,
    input  logic                       rst_in,
    input  logic                       start,
    input  logic [7:0]                 s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [ADDR_WIDTH-1:0]      wr_addr,
    output logic [RAM1_DATA_WIDTH-1:0] ram1_wdata,
    output logic [RAM2_DATA_WIDTH-1:0] ram2_wdata,
    output logic                       we,
    output logic                       load_done,
    output logic                       load_err,
    output logic [ADDR_WIDTH-1:0]      nodes_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        COLLECT,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    state_t                  state;
    state_t                  state_nxt;
    logic [2:0]              byte_cnt;
    logic [ADDR_WIDTH-1:0]   node_total;
    logic                    accept;
    logic                    start_ok;
    logic                    hdr_bad;
    logic [ADDR_WIDTH-1:0]   loaded_inc;

    assign accept     = s_valid & s_ready;
    assign start_ok   = start & ((state == IDLE) | (state == DONE) | (state == ERR));
    assign hdr_bad    = (s_data == 8'd0) | ({1'b0, s_data} > DEPTH_W);
    assign loaded_inc = nodes_loaded + 1'b1;

    // State register
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = HDR;
            HDR:     if (accept) state_nxt = hdr_bad ? ERR : COLLECT;
            COLLECT: if (accept && byte_cnt == 3'd7) state_nxt = WRITE;
            WRITE:   state_nxt = (loaded_inc == node_total) ? DONE : COLLECT;
            DONE:    if (start_ok) state_nxt = HDR;
            ERR:     if (start_ok) state_nxt = HDR;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake, strobe and status outputs
    always_comb begin
        s_ready   = 1'b0;
        we        = 1'b0;
        load_done = 1'b0;
        load_err  = 1'b0;
        case (state)
            HDR:     s_ready   = 1'b1;
            COLLECT: s_ready   = 1'b1;
            WRITE:   we        = 1'b1;
            DONE:    load_done = 1'b1;
            ERR:     load_err  = 1'b1;
            default: ;
        endcase
    end

    // Record assembly: the word registers shift bytes in MSB first, so the
    // oldest, unused upper bytes fall off the top by the end of the record.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            byte_cnt     <= '0;
            node_total   <= '0;
            nodes_loaded <= '0;
            wr_addr      <= '0;
            ram1_wdata   <= '0;
            ram2_wdata   <= '0;
        end else begin
            if (start_ok) begin
                byte_cnt     <= '0;
                nodes_loaded <= '0;
            end
            if (state == HDR && accept) begin
                node_total <= ADDR_WIDTH'(s_data);
            end
            if (state == COLLECT && accept) begin
                byte_cnt <= byte_cnt + 3'd1;
                if (byte_cnt <= 3'd4) begin
                    ram1_wdata <= {ram1_wdata[RAM1_DATA_WIDTH-9:0], s_data};
                end else begin
                    ram2_wdata <= {ram2_wdata[RAM2_DATA_WIDTH-9:0], s_data};
                end
                if (byte_cnt == 3'd7) begin
                    wr_addr <= nodes_loaded;
                end
            end
            if (state == WRITE) begin
                nodes_loaded <= loaded_inc;
                byte_cnt     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bdd_node_loader.sv
// Directed bench for bdd_node_loader: table of node records with
// hand-computed SRAM words, plus reset/start/error sequences.
module tb_bdd_node_loader;

    logic        clk;
    logic        rst_in;
    logic        start;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  wr_addr;
    logic [33:0] ram1_wdata;
    logic [17:0] ram2_wdata;
    logic        we;
    logic        load_done;
    logic        load_err;
    logic [7:0]  nodes_loaded;

    int n_chk;
    int n_fail;
    int we_cnt;

    typedef struct packed {
        logic [63:0] rec;
        logic [33:0] e1;
        logic [17:0] e2;
    } vec_t;

    vec_t tbl [4];

    bdd_node_loader dut (
        .clk         (clk),
        .rst_in      (rst_in),
        .start       (start),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .wr_addr     (wr_addr),
        .ram1_wdata  (ram1_wdata),
        .ram2_wdata  (ram2_wdata),
        .we          (we),
        .load_done   (load_done),
        .load_err    (load_err),
        .nodes_loaded(nodes_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count write strobes, sampled mid-cycle
    always @(negedge clk) begin
        if (we) we_cnt <= we_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok      = 1'b0;
        s_data  = b;
        s_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = s_ready;
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (!ok) chk("byte_timeout", 64'd0, 64'd1);
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_rec(input int vi, input int gap, input int addr);
        for (int j = 0; j < 7; j++) begin
            send_byte(tbl[vi].rec[63-8*j -: 8], gap);
        end
        send_byte(tbl[vi].rec[7:0], 0);
        chk("we", 64'(we), 64'd1);
        chk("wr_addr", 64'(wr_addr), 64'(addr));
        chk("ram1_wdata", 64'(ram1_wdata), 64'(tbl[vi].e1));
        chk("ram2_wdata", 64'(ram2_wdata), 64'(tbl[vi].e2));
        chk("s_ready_write", 64'(s_ready), 64'd0);
        @(negedge clk);
        chk("we_one_cycle", 64'(we), 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        chk({tag, "_we"}, 64'(we), 64'd0);
        chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        chk({tag, "_ram1"}, 64'(ram1_wdata), 64'd0);
        chk({tag, "_ram2"}, 64'(ram2_wdata), 64'd0);
        chk({tag, "_done"}, 64'(load_done), 64'd0);
        chk({tag, "_err"}, 64'(load_err), 64'd0);
        chk({tag, "_nodes"}, 64'(nodes_loaded), 64'd0);
    endtask

    initial begin
        int w0;
        tbl[0] = '{64'hFF12345678FFABCD, 34'h312345678, 18'h3ABCD};
        tbl[1] = '{64'h0000000001000002, 34'h000000001, 18'h00002};
        tbl[2] = '{64'h01AA5500FF128001, 34'h1AA5500FF, 18'h28001};
        tbl[3] = '{64'hC2DEADBEEF040000, 34'h2DEADBEEF, 18'h00000};

        n_chk   = 0;
        n_fail  = 0;
        we_cnt  = 0;
        start   = 1'b0;
        s_data  = 8'h00;
        s_valid = 1'b0;
        rst_in  = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_s_ready", 64'(s_ready), 64'd0);

        // Two nodes back-to-back
        pulse_start();
        send_byte(8'h02, 0);
        send_rec(0, 0, 0);
        chk("nodes_after1", 64'(nodes_loaded), 64'd1);
        chk("done_early", 64'(load_done), 64'd0);
        send_rec(1, 0, 1);
        chk("load_done", 64'(load_done), 64'd1);
        chk("nodes_loaded2", 64'(nodes_loaded), 64'd2);
        chk("we_count2", 64'(we_cnt), 64'd2);
        s_valid = 1'b1;
        s_data  = 8'h55;
        repeat (3) @(negedge clk);
        chk("done_s_ready", 64'(s_ready), 64'd0);
        chk("done_held", 64'(load_done), 64'd1);
        s_valid = 1'b0;

        // Restart from DONE, one node with s_valid gaps
        pulse_start();
        chk("restart_done_clr", 64'(load_done), 64'd0);
        chk("restart_nodes_clr", 64'(nodes_loaded), 64'd0);
        send_byte(8'h01, 1);
        send_rec(0, 1, 0);
        chk("gap_done", 64'(load_done), 64'd1);
        chk("gap_nodes", 64'(nodes_loaded), 64'd1);

        // Header of zero nodes
        w0 = we_cnt;
        pulse_start();
        send_byte(8'h00, 0);
        chk("hdr0_err", 64'(load_err), 64'd1);
        chk("hdr0_s_ready", 64'(s_ready), 64'd0);
        // Header one above DEPTH
        pulse_start();
        chk("err_clr", 64'(load_err), 64'd0);
        send_byte(8'h21, 0);
        chk("hdr21_err", 64'(load_err), 64'd1);
        s_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("err_s_ready", 64'(s_ready), 64'd0);
        s_valid = 1'b0;
        chk("err_no_we", 64'(we_cnt), 64'(w0));

        // Reset in the middle of node 1 of a 3-node load
        pulse_start();
        send_byte(8'h03, 0);
        send_rec(1, 0, 0);
        for (int j = 0; j < 4; j++) send_byte(tbl[2].rec[63-8*j -: 8], 0);
        w0 = we_cnt;
        rst_in = 1'b1;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst_in  = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hAA;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", 64'(s_ready), 64'd0);
        chk("post_rst_no_we", 64'(we_cnt), 64'(w0));
        s_valid = 1'b0;
        pulse_start();
        send_byte(8'h01, 0);
        send_rec(2, 0, 0);
        chk("fresh_done", 64'(load_done), 64'd1);

        // start during COLLECT is ignored
        pulse_start();
        send_byte(8'h02, 0);
        for (int j = 0; j < 3; j++) send_byte(tbl[3].rec[63-8*j -: 8], 0);
        pulse_start();
        chk("collect_s_ready", 64'(s_ready), 64'd1);
        for (int j = 3; j < 7; j++) send_byte(tbl[3].rec[63-8*j -: 8], 0);
        send_byte(tbl[3].rec[7:0], 0);
        chk("ign_we", 64'(we), 64'd1);
        chk("ign_addr", 64'(wr_addr), 64'd0);
        chk("ign_ram1", 64'(ram1_wdata), 64'(tbl[3].e1));
        chk("ign_ram2", 64'(ram2_wdata), 64'(tbl[3].e2));
        @(negedge clk);
        send_rec(1, 0, 1);
        chk("ign_done", 64'(load_done), 64'd1);
        chk("ign_nodes", 64'(nodes_loaded), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bdd_node_loader.md
BDD_NODE_LOADER -- requirements
Module: bdd_node_loader

Interface
REQ-001 The block SHALL have parameter RAM1_DATA_WIDTH, default 34, width of the coefficient/threshold node word.
REQ-002 The block SHALL have parameter RAM2_DATA_WIDTH, default 18, width of the child-pointer node word.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 8, width of the node address.
REQ-004 The block SHALL have parameter DEPTH, default 32, maximum node count.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_in, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: single-cycle load request.
REQ-008 The block SHALL have port s_data, input, 8 bits: stream byte.
REQ-009 The block SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-010 The block SHALL have port s_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-011 The block SHALL have port wr_addr, output, ADDR_WIDTH bits: node address for both SRAM write ports.
REQ-012 The block SHALL have port ram1_wdata, output, RAM1_DATA_WIDTH bits: coefficient/threshold word.
REQ-013 The block SHALL have port ram2_wdata, output, RAM2_DATA_WIDTH bits: child-pointer word.
REQ-014 The block SHALL have port we, output, 1 bit: write strobe shared by both SRAMs.
REQ-015 The block SHALL have port load_done, output, 1 bit: level, table fully written.
REQ-016 The block SHALL have port load_err, output, 1 bit: level, header rejected.
REQ-017 The block SHALL have port nodes_loaded, output, ADDR_WIDTH bits: count of completed node writes.

Function
REQ-018 The block SHALL implement states IDLE, HDR, COLLECT, WRITE, DONE and ERR.
REQ-019 A byte SHALL be accepted only in a cycle where s_valid=1 and s_ready=1.
REQ-020 s_ready SHALL be 1 only in HDR and COLLECT.
REQ-021 start in IDLE, DONE or ERR SHALL enter HDR, clear load_done, load_err and nodes_loaded, and zero the byte and node counters.
REQ-022 start in HDR, COLLECT or WRITE SHALL be ignored.
REQ-023 In HDR, the accepted byte N SHALL be stored as the node count.
REQ-024 N=0 or N>DEPTH SHALL go to ERR; otherwise the block SHALL go to COLLECT.
REQ-025 Each node record SHALL be 8 bytes, most-significant byte first: bytes 0-4 form a 40-bit value and ram1_wdata = its low RAM1_DATA_WIDTH bits; bytes 5-7 form a 24-bit value and ram2_wdata = its low RAM2_DATA_WIDTH bits; unused upper bits are discarded.
REQ-026 Accepting byte 7 of a record SHALL go to WRITE on the next edge.
REQ-027 WRITE SHALL last exactly one cycle with we=1, wr_addr = node index (0-based), and both data words stable.
REQ-028 we SHALL be 0 in every state other than WRITE.
REQ-029 nodes_loaded SHALL increment on the edge leaving WRITE.
REQ-030 On leaving WRITE, the block SHALL go to DONE if the incremented count equals N, else to COLLECT with the byte counter at 0.
REQ-031 In DONE, load_done SHALL be 1 and held until start or reset.
REQ-032 In ERR, load_err SHALL be 1 and held until start or reset.
REQ-033 In DONE and ERR, s_ready SHALL be 0 and extra stream bytes SHALL not be consumed.
REQ-034 s_valid gaps SHALL stall the byte counter with no effect on the assembled data.
REQ-035 The node index SHALL never exceed DEPTH-1, so no address wrap can occur.
REQ-036 wr_addr, ram1_wdata and ram2_wdata SHALL be registered outputs.

Reset
REQ-037 rst_in=1 SHALL immediately force IDLE, s_ready=0, we=0, wr_addr=0, ram1_wdata=0, ram2_wdata=0, load_done=0, load_err=0, nodes_loaded=0.
REQ-038 Reset asserted mid-record or during WRITE SHALL abort the load; no further we pulse SHALL occur until a new start.
REQ-039 On release of rst_in, the block SHALL remain in IDLE until start.

Verification
REQ-040 start, then header 0x02 and two records with s_valid held high -> exactly two we pulses at wr_addr 0 and 1, each one cycle after its 8th byte; load_done=1; nodes_loaded=2.
REQ-041 Record bytes 0xFF,0x12,0x34,0x56,0x78,0xFF,0xAB,0xCD -> ram1_wdata=34'h312345678 and ram2_wdata=18'h3ABCD while we=1.
REQ-042 Header 0x00, and separately header 0x21 with DEPTH=32 -> load_err=1, no we pulse, s_ready=0 afterwards.
REQ-043 s_valid toggled every other cycle across a 1-node load -> identical write data and address to the back-to-back case; s_ready=0 during the WRITE cycle.
REQ-044 rst_in pulsed after the 4th byte of node 1 of a 3-node load -> all outputs zero at once, no we, idle until start; a fresh start loads correctly from address 0.
REQ-045 start asserted during COLLECT -> ignored; start asserted in DONE -> new load begins with load_done cleared.
